single_sum_stream: RTL and testbench

Streaming single-precision (IEEE-754 binary32) vector reducer. It accepts packets of one or more beats, each beat carrying LANES elements, and reduces each beat through a pipelined single_add tree. It then accumulates the beat sums across the packet and presents one scalar result per packet on a valid/ready output. It is the packet-aware, back-pressured successor to the fixed-width one-shot sum tree, and sits between vector producers (dot-product lanes, filter taps) and scalar consumers.

---
 rtl/single_sum_stream.sv | 199 +++++++++++++++++++
 tb/tb_single_sum_stream.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/single_sum_stream.sv
// rtl/single_sum_stream.sv - packet-aware binary32 vector reducer with pipelined adder tree
//
// single_add: registered binary32 adder, 1-cycle latency, round-to-nearest-even.
//   clk - clock; a, b - operands; y - registered sum.
//   Denormal inputs are treated as signed zero, underflow flushes to signed zero,
//   overflow saturates to infinity. NaN/Inf operands get no special handling.
//
// single_sum_stream: reduces each LANES-wide beat through a single_add tree, then
// accumulates beat sums across a packet and holds one scalar result per packet.
//   clk, rst                        - clock, synchronous active-high reset
//   in_valid/in_ready               - beat handshake
//   in_data[LANES], in_keep         - beat elements and per-lane enables
//   in_last, in_abs                 - packet end marker, |x| mode (taken from first beat)
//   out_valid/out_ready             - result handshake
//   out_sum, out_beats              - packet sum and saturating beat count

module single_add (
  input  logic        clk,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] y
);
  logic              swap, sx, sy, same, sticky, round_up;
  logic [7:0]        ex, ey, d;
  logic [23:0]       mx, my;
  logic [26:0]       al, norm;
  logic [27:0]       raw;
  logic [4:0]        lz;
  logic [24:0]       rnd;
  logic [22:0]       mant;
  logic signed [9:0] e_norm, e_fin;
  logic [31:0]       res;

  always_comb begin
    // x is always the operand of larger magnitude, so the subtraction never goes negative
    swap = a[30:0] < b[30:0];
    sx   = swap ? b[31] : a[31];
    sy   = swap ? a[31] : b[31];
    ex   = swap ? b[30:23] : a[30:23];
    ey   = swap ? a[30:23] : b[30:23];
    mx   = (ex == 8'd0) ? 24'd0 : {1'b1, (swap ? b[22:0] : a[22:0])};
    my   = (ey == 8'd0) ? 24'd0 : {1'b1, (swap ? a[22:0] : b[22:0])};
    same = (sx == sy);
    d    = ex - ey;

    // align y with guard/round bits; everything shifted out folds into the sticky bit
    if (d > 8'd26) begin
      al     = 27'd0;
      sticky = |my;
    end else begin
      al     = {my, 3'b000} >> d;
      sticky = |({my, 3'b000} & ~({27{1'b1}} << d));
    end
    al[0] = al[0] | sticky;

    raw = same ? ({1'b0, mx, 3'b000} + {1'b0, al}) : ({1'b0, mx, 3'b000} - {1'b0, al});

    lz = 5'd0;
    for (int i = 0; i < 27; i++) begin
      if (raw[i]) lz = 5'(26 - i);
    end

    if (raw[27]) begin
      norm   = {raw[27:2], raw[1] | raw[0]};
      e_norm = $signed({2'b00, ex}) + 10'sd1;
    end else begin
      norm   = raw[26:0] << lz;
      e_norm = $signed({2'b00, ex}) - $signed({5'b00000, lz});
    end

    round_up = norm[2] & (norm[1] | norm[0] | norm[3]);
    rnd      = {1'b0, norm[26:3]} + {24'd0, round_up};
    if (rnd[24]) begin
      mant  = rnd[23:1];
      e_fin = e_norm + 10'sd1;
    end else begin
      mant  = rnd[22:0];
      e_fin = e_norm;
    end

    // exact cancellation gives +0; only (-0) + (-0) keeps the negative sign
    if (raw == 28'd0)          res = {same & sx, 31'd0};
    else if (e_fin >= 10'sd255) res = {sx, 8'hFF, 23'd0};
    else if (e_fin <= 10'sd0)   res = {sx, 31'd0};
    else                        res = {sx, e_fin[7:0], mant};
  end

  always_ff @(posedge clk) y <= res;
endmodule

module single_sum_stream #(
  parameter int LANES = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data [LANES],
  input  logic [LANES-1:0] in_keep,
  input  logic             in_last,
  input  logic             in_abs,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_sum,
  output logic [CNT_W-1:0] out_beats
);
  localparam int          LEVELS   = $clog2(LANES);
  localparam int          PAD      = 1 << LEVELS;
  localparam logic [31:0] NEG_ZERO = 32'h8000_0000;

  logic             first, abs_q, abs_eff, accept, last_inflight, acc_last_d;
  logic             tag_v, tag_f, tag_l;
  logic [CNT_W-1:0] beat_cnt;
  logic [31:0]      acc_a, acc_b, acc_y;
  // heap-ordered tree: leaves at PAD..2*PAD-1, node k = tree[2k] + tree[2k+1], root at 1
  logic [31:0]      tree [1:2*PAD-1];

  assign in_ready = !out_valid && !last_inflight;
  assign accept   = in_valid && in_ready;
  assign abs_eff  = first ? in_abs : abs_q;

  for (genvar i = 0; i < PAD; i++) begin : g_lane
    if (i < LANES) begin : g_real
      assign tree[PAD+i] = !in_keep[i] ? NEG_ZERO :
                           abs_eff     ? {1'b0, in_data[i][30:0]} : in_data[i];
    end else begin : g_pad
      assign tree[PAD+i] = NEG_ZERO;
    end
  end

  for (genvar k = 1; k < PAD; k++) begin : g_node
    single_add u_add (.clk(clk), .a(tree[2*k]), .b(tree[2*k+1]), .y(tree[k]));
  end

  // {valid, first, last} tags ride alongside the tree so they meet the root sum
  if (LEVELS == 0) begin : g_no_pipe
    assign tag_v = accept;
    assign tag_f = first;
    assign tag_l = in_last;
  end else begin : g_pipe
    logic [LEVELS-1:0] sv, sf, sl;
    always_ff @(posedge clk) begin
      if (rst) sv <= '0;
      else begin
        sv[0] <= accept;
        for (int j = 1; j < LEVELS; j++) sv[j] <= sv[j-1];
      end
      sf[0] <= first;
      sl[0] <= in_last;
      for (int j = 1; j < LEVELS; j++) begin
        sf[j] <= sf[j-1];
        sl[j] <= sl[j-1];
      end
    end
    assign tag_v = sv[LEVELS-1];
    assign tag_f = sf[LEVELS-1];
    assign tag_l = sl[LEVELS-1];
  end

  // adding -0.0 is exact, so idle cycles leave the running sum bit-identical
  assign acc_a = (tag_v && tag_f) ? NEG_ZERO : acc_y;
  assign acc_b = tag_v ? tree[1] : NEG_ZERO;
  single_add u_acc (.clk(clk), .a(acc_a), .b(acc_b), .y(acc_y));

  always_ff @(posedge clk) begin
    if (rst) begin
      first         <= 1'b1;
      abs_q         <= 1'b0;
      beat_cnt      <= '0;
      last_inflight <= 1'b0;
      acc_last_d    <= 1'b0;
      out_valid     <= 1'b0;
      out_sum       <= 32'h0;
      out_beats     <= '0;
    end else begin
      acc_last_d <= tag_v && tag_l;
      if (accept) begin
        first <= in_last;
        if (first) begin
          abs_q    <= in_abs;
          beat_cnt <= CNT_W'(1);
        end else if (beat_cnt != {CNT_W{1'b1}}) begin
          beat_cnt <= beat_cnt + CNT_W'(1);
        end
      end
      // beat_cnt cannot move before the hold loads: no beat is accepted while a tail is in flight
      if (accept && in_last) last_inflight <= 1'b1;
      else if (acc_last_d)   last_inflight <= 1'b0;
      if (acc_last_d) begin
        out_valid <= 1'b1;
        out_sum   <= acc_y;
        out_beats <= beat_cnt;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_single_sum_stream.sv
// tb/tb_single_sum_stream.sv - self-checking bench for single_sum_stream (LANES=4, CNT_W=3)
module tb_single_sum_stream;
  localparam logic [31:0] ONE = 32'h3F80_0000, TWO = 32'h4000_0000;
  localparam logic [31:0] THREE = 32'h4040_0000, FOUR = 32'h4080_0000;
  localparam logic [127:0] B1234 = {FOUR, THREE, TWO, ONE};
  localparam logic [127:0] B1111 = {ONE, ONE, ONE, ONE};
  localparam logic [127:0] B4444 = {FOUR, FOUR, FOUR, FOUR};

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, in_last, in_abs, out_valid, out_ready;
  logic [31:0] in_data [4];
  logic [3:0]  in_keep;
  logic [31:0] out_sum;
  logic [2:0]  out_beats;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int rise_cyc = 0;
  logic ov_prev = 1'b0;
  logic [31:0] q_sum [$];
  logic [2:0]  q_beats [$];
  int          q_rise [$];

  single_sum_stream #(.LANES(4), .CNT_W(3)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_keep(in_keep), .in_last(in_last), .in_abs(in_abs),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum), .out_beats(out_beats)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // result monitor: samples between negedge and the next posedge, logs each completed handshake
  always begin
    @(negedge clk);
    #2;
    if (out_valid && !ov_prev) rise_cyc = cyc;
    if (out_valid && out_ready) begin
      q_sum.push_back(out_sum);
      q_beats.push_back(out_beats);
      q_rise.push_back(rise_cyc);
    end
    ov_prev = out_valid;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
    $fatal(1, "watchdog expired");
  end

  function automatic logic [31:0] int2f(input int v);
    int m, e;
    logic s;
    if (v == 0) return 32'h0;
    s = (v < 0);
    m = s ? -v : v;
    e = 0;
    while ((m >> e) > 1) e++;
    return {s, 8'(127 + e), 23'(m << (23 - e))};
  endfunction

  task automatic send_beat(input logic [127:0] d, input logic [3:0] keep, input logic last,
                           input logic abs_m, output int t_acc);
    int n;
    for (int i = 0; i < 4; i++) in_data[i] = d[32*i +: 32];
    in_keep = keep; in_last = last; in_abs = abs_m; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 300) begin @(negedge clk); n++; end
    n_tests++;
    if (!in_ready) begin
      n_fail++;
      $display("FAIL send_timeout: in_ready=%0b after %0d cycles, want 1", in_ready, n);
      t_acc = -1;
    end else t_acc = cyc;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic get_result(output logic [31:0] s, output logic [2:0] b, output int r, output bit ok);
    int n;
    n = 0;
    while (q_sum.size() == 0 && n < 100) begin @(negedge clk); n++; end
    n_tests++;
    if (q_sum.size() == 0) begin
      n_fail++;
      $display("FAIL result_timeout: no result after %0d cycles, want one", n);
      ok = 0; s = '0; b = '0; r = -1;
    end else begin
      ok = 1; s = q_sum.pop_front(); b = q_beats.pop_front(); r = q_rise.pop_front();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_abs = 1'b0; in_keep = '0; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) in_data[i] = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_tests++; if (out_sum !== 32'h0) begin n_fail++; $display("FAIL reset_out_sum: got %h want 00000000", out_sum); end
    n_tests++; if (out_beats !== 3'd0) begin n_fail++; $display("FAIL reset_out_beats: got %0d want 0", out_beats); end
  endtask

  task automatic test_single_beat();
    int t, r; logic [31:0] s; logic [2:0] b; bit ok;
    send_beat(B1234, 4'hF, 1'b1, 1'b0, t);
    get_result(s, b, r, ok);
    if (ok) begin
      n_tests++; if (s !== 32'h4120_0000) begin n_fail++; $display("FAIL single_sum: got %h want 41200000", s); end
      n_tests++; if (b !== 3'd1) begin n_fail++; $display("FAIL single_beats: got %0d want 1", b); end
      n_tests++; if (r - t != 4) begin n_fail++; $display("FAIL single_latency: got %0d want 4", r - t); end
    end
  endtask

  task automatic test_back_to_back();
    int t1, t2, t3, r; logic [31:0] s; logic [2:0] b; bit ok;
    send_beat(B1234, 4'hF, 1'b0, 1'b0, t1);
    send_beat(B1234, 4'hF, 1'b0, 1'b0, t2);
    send_beat(B4444, 4'hF, 1'b1, 1'b0, t3);
    n_tests++; if (t2 != t1 + 1 || t3 != t2 + 1) begin n_fail++; $display("FAIL b2b_accept: got gaps %0d,%0d want 1,1", t2 - t1, t3 - t2); end
    get_result(s, b, r, ok);
    if (ok) begin
      n_tests++; if (s !== 32'h4210_0000) begin n_fail++; $display("FAIL b2b_sum: got %h want 42100000", s); end
      n_tests++; if (b !== 3'd3) begin n_fail++; $display("FAIL b2b_beats: got %0d want 3", b); end
      n_tests++; if (r - t3 != 4) begin n_fail++; $display("FAIL b2b_latency: got %0d want 4", r - t3); end
    end
  endtask

  task automatic test_abs();
    int t, r; logic [31:0] s; logic [2:0] b; bit ok;
    send_beat({4{32'hBF80_0000}}, 4'hF, 1'b0, 1'b1, t);
    send_beat({4{32'hBF80_0000}}, 4'hF, 1'b1, 1'b0, t);
    get_result(s, b, r, ok);
    if (ok) begin
      n_tests++; if (s !== 32'h4100_0000) begin n_fail++; $display("FAIL abs_sum: got %h want 41000000", s); end
      n_tests++; if (b !== 3'd2) begin n_fail++; $display("FAIL abs_beats: got %0d want 2", b); end
    end
  endtask

  task automatic test_keep_zero();
    int t, r; logic [31:0] s; logic [2:0] b; bit ok;
    send_beat(B1234, 4'b0101, 1'b1, 1'b0, t);
    get_result(s, b, r, ok);
    n_tests++; if (ok && s !== 32'h4080_0000) begin n_fail++; $display("FAIL keep_sum: got %h want 40800000", s); end
    send_beat({4{32'h8000_0000}}, 4'hF, 1'b1, 1'b0, t);
    get_result(s, b, r, ok);
    n_tests++; if (ok && s !== 32'h8000_0000) begin n_fail++; $display("FAIL negzero_sum: got %h want 80000000", s); end
    send_beat(B1234, 4'h0, 1'b1, 1'b0, t);
    get_result(s, b, r, ok);
    n_tests++; if (ok && s !== 32'h8000_0000) begin n_fail++; $display("FAIL keep0_sum: got %h want 80000000", s); end
    send_beat({32'h0, 32'h8000_0000, 32'h0, 32'h8000_0000}, 4'hF, 1'b1, 1'b0, t);
    get_result(s, b, r, ok);
    n_tests++; if (ok && s !== 32'h0) begin n_fail++; $display("FAIL poszero_sum: got %h want 00000000", s); end
  endtask

  task automatic test_throughput();
    int t1, t2, r; logic [31:0] s; logic [2:0] b; bit ok;
    send_beat(B1111, 4'hF, 1'b1, 1'b0, t1);
    send_beat(B1234, 4'hF, 1'b1, 1'b0, t2);
    n_tests++; if (t2 - t1 != 5) begin n_fail++; $display("FAIL throughput_gap: got %0d want 5", t2 - t1); end
    get_result(s, b, r, ok);
    n_tests++; if (ok && s !== 32'h4080_0000) begin n_fail++; $display("FAIL tput_sum0: got %h want 40800000", s); end
    get_result(s, b, r, ok);
    n_tests++; if (ok && s !== 32'h4120_0000) begin n_fail++; $display("FAIL tput_sum1: got %h want 41200000", s); end
  endtask

  task automatic test_backpressure();
    int t, r, n, x; logic [31:0] s, s0; logic [2:0] b; bit ok;
    out_ready = 1'b0;
    send_beat(B1234, 4'hF, 1'b1, 1'b0, t);
    n = 0;
    while (!out_valid && n < 50) begin @(negedge clk); n++; end
    n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid: got %b want 1", out_valid); end
    s0 = out_sum;
    n_tests++; if (s0 !== 32'h4120_0000) begin n_fail++; $display("FAIL bp_sum: got %h want 41200000", s0); end
    for (int i = 0; i < 4; i++) in_data[i] = ONE;
    in_keep = 4'hF; in_last = 1'b1; in_abs = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_hold_valid[%0d]: got %b want 1", i, out_valid); end
      n_tests++; if (out_sum !== s0) begin n_fail++; $display("FAIL bp_hold_sum[%0d]: got %h want %h", i, out_sum, s0); end
      n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready[%0d]: got %b want 0", i, in_ready); end
    end
    out_ready = 1'b1;
    x = cyc;
    n = 0;
    while (!in_ready && n < 20) begin @(negedge clk); n++; end
    n_tests++; if (cyc != x + 1) begin n_fail++; $display("FAIL bp_next_accept: got cycle +%0d want +1", cyc - x); end
    @(negedge clk);
    in_valid = 1'b0;
    get_result(s, b, r, ok);
    n_tests++; if (ok && s !== 32'h4120_0000) begin n_fail++; $display("FAIL bp_first: got %h want 41200000", s); end
    get_result(s, b, r, ok);
    n_tests++; if (ok && (s !== 32'h4080_0000 || b !== 3'd1)) begin n_fail++; $display("FAIL bp_second: got %h/%0d want 40800000/1", s, b); end
  endtask

  task automatic test_saturate();
    int t, r; logic [31:0] s; logic [2:0] b; bit ok;
    for (int i = 0; i < 9; i++) send_beat(B1111, 4'hF, 1'(i == 8), 1'b0, t);
    get_result(s, b, r, ok);
    if (ok) begin
      n_tests++; if (s !== 32'h4210_0000) begin n_fail++; $display("FAIL sat_sum: got %h want 42100000", s); end
      n_tests++; if (b !== 3'd7) begin n_fail++; $display("FAIL sat_beats: got %0d want 7", b); end
    end
  endtask

  task automatic test_reset_mid_packet();
    int t, r; logic [31:0] s; logic [2:0] b; bit ok;
    send_beat(B1234, 4'hF, 1'b0, 1'b0, t);
    send_beat(B1234, 4'hF, 1'b0, 1'b0, t);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    n_tests++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_state: got ready=%b valid=%b want 1/0", in_ready, out_valid); end
    send_beat(B1111, 4'hF, 1'b1, 1'b0, t);
    get_result(s, b, r, ok);
    if (ok) begin
      n_tests++; if (s !== 32'h4080_0000) begin n_fail++; $display("FAIL midrst_sum: got %h want 40800000", s); end
      n_tests++; if (b !== 3'd1) begin n_fail++; $display("FAIL midrst_beats: got %0d want 1", b); end
    end
    repeat (20) @(negedge clk);
    n_tests++; if (q_sum.size() != 0) begin n_fail++; $display("FAIL midrst_extra: got %0d extra results want 0", q_sum.size()); end
  endtask

  task automatic test_random();
    int nb, t, r, n, v, ve, total;
    logic abs_m, allneg;
    logic [127:0] d;
    logic [3:0] k;
    logic [31:0] bits, be, s, want;
    logic [2:0] b;
    bit ok, stall;
    for (int p = 0; p < 30; p++) begin
      nb = $urandom_range(1, 5);
      abs_m = 1'($urandom_range(0, 1));
      stall = ($urandom_range(0, 2) == 0);
      total = 0; allneg = 1'b1;
      out_ready = !stall;
      for (int bt = 0; bt < nb; bt++) begin
        k = 4'($urandom);
        for (int l = 0; l < 4; l++) begin
          if ($urandom_range(0, 3) == 0) v = 0;
          else v = $urandom_range(0, 2000) - 1000;
          bits = int2f(v);
          if (v == 0 && $urandom_range(0, 1) == 1) bits = 32'h8000_0000;
          d[32*l +: 32] = bits;
          if (k[l]) begin
            ve = (abs_m && v < 0) ? -v : v;
            be = abs_m ? {1'b0, bits[30:0]} : bits;
            total += ve;
            if (be != 32'h8000_0000) allneg = 1'b0;
          end
        end
        send_beat(d, k, 1'(bt == nb - 1), (bt == 0) ? abs_m : 1'($urandom_range(0, 1)), t);
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      want = allneg ? 32'h8000_0000 : int2f(total);
      if (stall) begin
        n = 0;
        while (!out_valid && n < 50) begin @(negedge clk); n++; end
        repeat ($urandom_range(1, 6)) @(negedge clk);
        out_ready = 1'b1;
      end
      get_result(s, b, r, ok);
      if (ok) begin
        n_tests++; if (s !== want) begin n_fail++; $display("FAIL rand_sum[%0d]: got %h want %h", p, s, want); end
        n_tests++; if (b !== 3'(nb)) begin n_fail++; $display("FAIL rand_beats[%0d]: got %0d want %0d", p, b, nb); end
        n_tests++; if (r - t != 4) begin n_fail++; $display("FAIL rand_latency[%0d]: got %0d want 4", p, r - t); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_beat();
    test_back_to_back();
    test_abs();
    test_keep_zero();
    test_throughput();
    test_backpressure();
    test_saturate();
    test_reset_mid_packet();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
